// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage core: load-use and branch stalls,
// plus EX and ID-branch operand forwarding from a shadow E/M/W record.
module hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            instr_d,
  input  logic [3:0]             instr_type_d,
  input  logic                   valid_d,
  output logic                   stall,
  output logic [1:0]             fwd_a_e,
  output logic [1:0]             fwd_b_e,
  output logic [1:0]             fwd_a_d,
  output logic [1:0]             fwd_b_d,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [2:0] {
    T_OTH = 3'd0,
    T_R   = 3'd1,
    T_I   = 3'd2,
    T_BR  = 3'd3,
    T_LD  = 3'd4
  } itype_e;

  typedef struct packed {
    itype_e     ty;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       valid;
  } rec_t;

  function automatic rec_t mk_rec(
    input logic [31:0] ins,
    input logic [3:0]  ty,
    input logic        v
  );
    rec_t r;
    r.ty    = (ty <= 4'd4) ? itype_e'(ty[2:0]) : T_OTH;
    r.rs    = ins[25:21];
    r.rt    = ins[20:16];
    r.valid = v;
    unique case (r.ty)
      T_R:       r.dst = ins[15:11];
      T_I, T_LD: r.dst = ins[20:16];
      default:   r.dst = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic use_rs(input rec_t r);
    return r.ty inside {T_R, T_I, T_BR, T_LD};
  endfunction

  function automatic logic use_rt(input rec_t r);
    return r.ty inside {T_R, T_BR};
  endfunction

  function automatic logic is_wr(input rec_t r);
    return r.valid && (r.dst != 5'd0)
        && (r.ty inside {T_R, T_I, T_LD});
  endfunction

  function automatic logic hits(input rec_t w, input rec_t d);
    return (use_rs(d) && w.dst == d.rs)
        || (use_rt(d) && w.dst == d.rt);
  endfunction

  // MEM only forwards ALU results; a load in MEM has no data yet.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       used,
    input rec_t       m,
    input rec_t       w
  );
    logic m_hit;
    logic w_hit;
    logic [1:0] sel;
    m_hit = used && is_wr(m) && (m.ty inside {T_R, T_I})
         && (m.dst == src);
    w_hit = used && is_wr(w) && (w.dst == src);
    priority case (1'b1)
      m_hit:   sel = 2'b01;
      w_hit:   sel = 2'b10;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  rec_t d_rec;
  rec_t e_q, e_d;
  rec_t m_q;
  rec_t w_q;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic ld_use, br_ex, br_mem, id_br;
  logic unused_ok;

  assign unused_ok = ^{instr_d[31:26], instr_d[10:0]};
  assign d_rec = mk_rec(instr_d, instr_type_d, valid_d);

  assign ld_use = is_wr(e_q) && (e_q.ty == T_LD)
               && hits(e_q, d_rec);
  assign br_ex  = (d_rec.ty == T_BR) && is_wr(e_q)
               && hits(e_q, d_rec);
  assign br_mem = (d_rec.ty == T_BR) && is_wr(m_q)
               && (m_q.ty == T_LD) && hits(m_q, d_rec);
  assign stall  = valid_d && (ld_use || br_ex || br_mem);

  assign fwd_a_e = e_q.valid
    ? fwd_sel(e_q.rs, use_rs(e_q), m_q, w_q) : 2'b00;
  assign fwd_b_e = e_q.valid
    ? fwd_sel(e_q.rt, use_rt(e_q), m_q, w_q) : 2'b00;

  assign id_br   = valid_d && (d_rec.ty == T_BR);
  assign fwd_a_d = id_br
    ? fwd_sel(d_rec.rs, use_rs(d_rec), m_q, w_q) : 2'b00;
  assign fwd_b_d = id_br
    ? fwd_sel(d_rec.rt, use_rt(d_rec), m_q, w_q) : 2'b00;

  always_comb begin
    e_d = (stall || !valid_d) ? '0 : d_rec;
    cnt_d = cnt_q;
    if (stall && !(&cnt_q))
      cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= e_q;
      w_q   <= m_q;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule
